// File: rtl/nn_pkg.sv
// Shared constants and types for the neural-network register bank.
package nn_pkg;

  // Select-vector indices beyond the coefficients, relative to NUM_COEFF.
  localparam int OFS_OFFSET  = 0;
  localparam int OFS_ENTRADA = 1;
  localparam int OFS_STATUS  = 2;
  localparam int OFS_START   = 3;
  localparam int NUM_EXTRA   = 4;

  localparam int STAT_BUSY  = 0;
  localparam int STAT_DONE  = 1;
  localparam int STAT_WRERR = 2;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } nn_state_e;

endpackage

// File: rtl/nn_addr_decode.sv
// Byte address -> one-hot register select; misaligned or out-of-map addresses flag unmapped.
module nn_addr_decode
  import nn_pkg::*;
#(
  parameter int                NUM_COEFF = 20,
  parameter int                ADDR_W    = 9,
  parameter logic [ADDR_W-1:0] BASE_ADDR = 'h00C
) (
  input  logic [ADDR_W-1:0]              i_addr,
  output logic [NUM_COEFF+NUM_EXTRA-1:0] o_sel,
  output logic                           o_unmapped
);

  logic [ADDR_W-1:0] w_rel;
  logic [ADDR_W-3:0] w_idx;
  logic              w_hit;

  assign w_rel = i_addr - BASE_ADDR;
  assign w_idx = w_rel[ADDR_W-1:2];
  assign w_hit = (i_addr[1:0] == 2'b00) && (i_addr >= BASE_ADDR) &&
                 (32'(w_idx) < NUM_COEFF + NUM_EXTRA);

  for (genvar g = 0; g < NUM_COEFF + NUM_EXTRA; g++) begin : g_sel
    assign o_sel[g] = w_hit && (32'(w_idx) == g);
  end

  assign o_unmapped = ~w_hit;

endmodule

// File: rtl/nn_reg_bank.sv
// Coefficient/offset/input storage, registered readback and start/busy/done control.
module nn_reg_bank
  import nn_pkg::*;
#(
  parameter int                NUM_COEFF = 20,
  parameter int                DATA_W    = 16,
  parameter int                ADDR_W    = 9,
  parameter logic [ADDR_W-1:0] BASE_ADDR = 'h00C
) (
  input  logic                        Clk,
  input  logic                        Reset_n,
  input  logic [ADDR_W-1:0]           Address,
  input  logic                        Write,
  input  logic                        Read,
  input  logic [DATA_W-1:0]           WriteData,
  output logic [DATA_W-1:0]           ReadData,
  output logic                        ReadValid,
  output logic [NUM_COEFF*DATA_W-1:0] Coeff,
  output logic [DATA_W-1:0]           Offset,
  output logic [DATA_W-1:0]           Entrada,
  output logic                        StartPulse,
  output logic                        Busy,
  input  logic                        Done
);

  localparam int NSEL      = NUM_COEFF + NUM_EXTRA;
  localparam int SEL_OFF   = NUM_COEFF + OFS_OFFSET;
  localparam int SEL_ENT   = NUM_COEFF + OFS_ENTRADA;
  localparam int SEL_STAT  = NUM_COEFF + OFS_STATUS;
  localparam int SEL_START = NUM_COEFF + OFS_START;

  logic [NSEL-1:0]                   w_sel;
  logic                              w_unmapped;
  nn_state_e                         r_state, w_state_nxt;
  logic [NUM_COEFF-1:0][DATA_W-1:0]  r_coeff;
  logic [DATA_W-1:0]                 r_offset, r_entrada, r_rdata, w_rdata;
  logic                              r_rvalid, r_start, r_done_flag, r_wrerr;
  logic                              w_cfg_sel, w_cfg_we, w_start_go, w_reject, w_done_evt;
  logic                              w_rd_en, w_stat_rd;

  nn_addr_decode #(
    .NUM_COEFF (NUM_COEFF),
    .ADDR_W    (ADDR_W),
    .BASE_ADDR (BASE_ADDR)
  ) u_dec (
    .i_addr     (Address),
    .o_sel      (w_sel),
    .o_unmapped (w_unmapped)
  );

  // Coefficients, offset and entrada occupy select indices 0..SEL_ENT.
  assign w_cfg_sel = |w_sel[SEL_ENT:0];
  assign w_rd_en   = Read && !Write;
  assign w_stat_rd = w_rd_en && w_sel[SEL_STAT];

  always_comb begin
    w_state_nxt = r_state;
    w_cfg_we    = 1'b0;
    w_start_go  = 1'b0;
    w_reject    = 1'b0;
    w_done_evt  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_cfg_we = Write && w_cfg_sel;
        if (Write && w_sel[SEL_START]) begin
          w_start_go  = 1'b1;
          w_state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        w_reject = Write && (w_cfg_sel || w_sel[SEL_START]);
        if (Done) begin
          w_done_evt  = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state <= ST_IDLE;
      r_start <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_start <= w_start_go;
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_coeff   <= '0;
      r_offset  <= '0;
      r_entrada <= '0;
    end else if (w_cfg_we) begin
      for (int k = 0; k < NUM_COEFF; k++)
        if (w_sel[k]) r_coeff[k] <= WriteData;
      if (w_sel[SEL_OFF]) r_offset  <= WriteData;
      if (w_sel[SEL_ENT]) r_entrada <= WriteData;
    end
  end

  // Sticky flags: a set in the same cycle as the clearing read survives.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_done_flag <= 1'b0;
      r_wrerr     <= 1'b0;
    end else begin
      r_done_flag <= w_done_evt | (r_done_flag & ~w_stat_rd);
      r_wrerr     <= w_reject   | (r_wrerr     & ~w_stat_rd);
    end
  end

  always_comb begin
    w_rdata = '0;
    if (!w_unmapped) begin
      for (int k = 0; k < NUM_COEFF; k++)
        if (w_sel[k]) w_rdata = r_coeff[k];
      if (w_sel[SEL_OFF]) w_rdata = r_offset;
      if (w_sel[SEL_ENT]) w_rdata = r_entrada;
      if (w_sel[SEL_STAT]) begin
        w_rdata[STAT_BUSY]  = (r_state == ST_RUN);
        w_rdata[STAT_DONE]  = r_done_flag;
        w_rdata[STAT_WRERR] = r_wrerr;
      end
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_rdata  <= '0;
      r_rvalid <= 1'b0;
    end else begin
      r_rvalid <= w_rd_en;
      if (w_rd_en) r_rdata <= w_rdata;
    end
  end

  assign Coeff      = r_coeff;
  assign Offset     = r_offset;
  assign Entrada    = r_entrada;
  assign ReadData   = r_rdata;
  assign ReadValid  = r_rvalid;
  assign StartPulse = r_start;
  assign Busy       = (r_state == ST_RUN);

endmodule

// File: tb/tb_nn_reg_bank.sv
// Bench for nn_reg_bank: default 20-coefficient map plus a 4-coefficient instance.
module tb_nn_reg_bank;

  logic        Clk = 1'b0;
  logic        Reset_n;
  logic [8:0]  Address;
  logic        Write, Read, Done;
  logic [15:0] WriteData, ReadData, Offset, Entrada;
  logic        ReadValid, StartPulse, Busy;
  logic [319:0] Coeff;

  logic [8:0]  a4;
  logic        w4, r4, d4, rv4, sp4, b4;
  logic [15:0] wd4, rd4, o4, e4;
  logic [63:0] c4;

  always #5 Clk = ~Clk;

  nn_reg_bank dut (
    .Clk(Clk), .Reset_n(Reset_n), .Address(Address), .Write(Write), .Read(Read),
    .WriteData(WriteData), .ReadData(ReadData), .ReadValid(ReadValid), .Coeff(Coeff),
    .Offset(Offset), .Entrada(Entrada), .StartPulse(StartPulse), .Busy(Busy), .Done(Done)
  );

  nn_reg_bank #(.NUM_COEFF(4)) dut4 (
    .Clk(Clk), .Reset_n(Reset_n), .Address(a4), .Write(w4), .Read(r4),
    .WriteData(wd4), .ReadData(rd4), .ReadValid(rv4), .Coeff(c4),
    .Offset(o4), .Entrada(e4), .StartPulse(sp4), .Busy(b4), .Done(d4)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: register contents and status as the map defines them.
  logic [15:0] m_coeff [20];
  logic [15:0] m_off, m_ent;
  logic        m_busy, m_done, m_wrerr;

  function automatic int idx_of(input logic [8:0] a, input int n);
    int rel;
    if (a[1:0] != 2'b00 || a < 9'd12) return -1;
    rel = (int'(a) - 12) / 4;
    return (rel < n + 4) ? rel : -1;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 20; i++) m_coeff[i] = 16'h0;
    m_off = 0; m_ent = 0; m_busy = 0; m_done = 0; m_wrerr = 0;
  endtask

  task automatic model_read(input logic [8:0] a, output logic [15:0] e);
    int i;
    i = idx_of(a, 20);
    e = 16'h0;
    if (i >= 0 && i < 20) e = m_coeff[i];
    else if (i == 20) e = m_off;
    else if (i == 21) e = m_ent;
    else if (i == 22) begin
      e = {13'h0, m_wrerr, m_done, m_busy};
      m_done = 0; m_wrerr = 0;
    end
  endtask

  task automatic do_write(input logic [8:0] a, input logic [15:0] d);
    int i;
    i = idx_of(a, 20);
    @(negedge Clk); Address = a; WriteData = d; Write = 1; Read = 0;
    @(negedge Clk); Write = 0;
    if (i >= 0) begin
      if (m_busy) begin
        if (i != 22) m_wrerr = 1;
      end else if (i < 20) m_coeff[i] = d;
      else if (i == 20) m_off = d;
      else if (i == 21) m_ent = d;
      else if (i == 23) m_busy = 1;
    end
  endtask

  task automatic do_read(input logic [8:0] a, output logic [15:0] d, output logic v);
    @(negedge Clk); Address = a; Read = 1; Write = 0;
    @(negedge Clk); Read = 0; d = ReadData; v = ReadValid;
  endtask

  task automatic read_check(input logic [8:0] a, input string nm);
    logic [15:0] d, e;
    logic v;
    do_read(a, d, v);
    model_read(a, e);
    n_checks++; if (d !== e) begin n_fail++; $display("FAIL %s data @%h: got %h want %h", nm, a, d, e); end
    n_checks++; if (v !== 1'b1) begin n_fail++; $display("FAIL %s valid @%h: got %b want 1", nm, a, v); end
  endtask

  task automatic check_regs(input string nm);
    for (int k = 0; k < 20; k++) begin
      n_checks++;
      if (Coeff[k*16 +: 16] !== m_coeff[k]) begin
        n_fail++; $display("FAIL %s coeff%0d: got %h want %h", nm, k, Coeff[k*16 +: 16], m_coeff[k]);
      end
    end
    n_checks++; if (Offset !== m_off) begin n_fail++; $display("FAIL %s offset: got %h want %h", nm, Offset, m_off); end
    n_checks++; if (Entrada !== m_ent) begin n_fail++; $display("FAIL %s entrada: got %h want %h", nm, Entrada, m_ent); end
    n_checks++; if (Busy !== m_busy) begin n_fail++; $display("FAIL %s busy: got %b want %b", nm, Busy, m_busy); end
  endtask

  task automatic test_reset();
    Reset_n = 0; Address = 0; Write = 0; Read = 0; WriteData = 0; Done = 0;
    a4 = 0; w4 = 0; r4 = 0; wd4 = 0; d4 = 0;
    model_reset();
    repeat (3) @(negedge Clk);
    Reset_n = 1;
    @(negedge Clk);
    check_regs("reset");
    n_checks++; if (ReadData !== 16'h0) begin n_fail++; $display("FAIL reset rdata: got %h want 0", ReadData); end
    n_checks++; if (ReadValid !== 1'b0) begin n_fail++; $display("FAIL reset rvalid: got %b want 0", ReadValid); end
    n_checks++; if (StartPulse !== 1'b0) begin n_fail++; $display("FAIL reset start: got %b want 0", StartPulse); end
    n_checks++; if ({c4, b4, sp4} !== 66'h0) begin n_fail++; $display("FAIL reset dut4: got %h want 0", {c4, b4, sp4}); end
  endtask

  task automatic test_directed();
    logic [8:0]  addrs [4];
    logic [15:0] vals  [4];
    addrs = '{9'h00C, 9'h058, 9'h05C, 9'h060};
    vals  = '{16'h1234, 16'hABCD, 16'h0055, 16'h7FFF};
    for (int i = 0; i < 4; i++) do_write(addrs[i], vals[i]);
    n_checks++; if (Coeff[15:0] !== 16'h1234) begin n_fail++; $display("FAIL dir coeff0: got %h want 1234", Coeff[15:0]); end
    n_checks++; if (Coeff[19*16 +: 16] !== 16'hABCD) begin n_fail++; $display("FAIL dir coeff19: got %h want abcd", Coeff[19*16 +: 16]); end
    n_checks++; if (Offset !== 16'h0055) begin n_fail++; $display("FAIL dir offset: got %h want 0055", Offset); end
    n_checks++; if (Entrada !== 16'h7FFF) begin n_fail++; $display("FAIL dir entrada: got %h want 7fff", Entrada); end
    for (int i = 0; i < 4; i++) read_check(addrs[i], "dir_read");
  endtask

  task automatic test_random();
    logic [8:0] a;
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 1) == 0) a = 9'(12 + 4 * $urandom_range(0, 21));
      else begin
        a = 9'($urandom_range(0, 511));
        if (a == 9'h068) a = 9'h069;
      end
      do_write(a, 16'($urandom));
      check_regs("rand_wr");
    end
    for (int n = 0; n < 30; n++) begin
      a = ($urandom_range(0, 3) == 0) ? 9'($urandom_range(0, 511)) : 9'(12 + 4 * $urandom_range(0, 23));
      read_check(a, "rand_rd");
    end
  endtask

  task automatic test_start();
    do_write(9'h068, 16'h0001);
    n_checks++; if (StartPulse !== 1'b1) begin n_fail++; $display("FAIL start pulse: got %b want 1", StartPulse); end
    n_checks++; if (Busy !== 1'b1) begin n_fail++; $display("FAIL start busy: got %b want 1", Busy); end
    @(negedge Clk);
    n_checks++; if (StartPulse !== 1'b0) begin n_fail++; $display("FAIL start pulse_end: got %b want 0", StartPulse); end
    read_check(9'h064, "start_status");
  endtask

  task automatic test_run_lock();
    do_write(9'h010, 16'hFFFF);
    n_checks++; if (StartPulse !== 1'b0) begin n_fail++; $display("FAIL lock pulse1: got %b want 0", StartPulse); end
    do_write(9'h068, 16'h0001);
    n_checks++; if (StartPulse !== 1'b0) begin n_fail++; $display("FAIL lock pulse2: got %b want 0", StartPulse); end
    check_regs("lock");
    read_check(9'h064, "lock_status1");
    read_check(9'h064, "lock_status2");
  endtask

  task automatic test_done();
    @(negedge Clk); Done = 1;
    @(negedge Clk); Done = 0;
    m_busy = 0; m_done = 1;
    n_checks++; if (Busy !== 1'b0) begin n_fail++; $display("FAIL done busy: got %b want 0", Busy); end
    read_check(9'h064, "done_status1");
    read_check(9'h064, "done_status2");
    @(negedge Clk); Done = 1;
    @(negedge Clk); Done = 0;
    read_check(9'h064, "idle_done_status");
  endtask

  task automatic test_back_to_back();
    do_write(9'h068, 16'h0);
    @(negedge Clk); Address = 9'h014; WriteData = 16'($urandom) | 16'h1; Write = 1; Done = 1;
    @(negedge Clk); Write = 0; Done = 0;
    m_wrerr = 1; m_busy = 0; m_done = 1;
    check_regs("wr_with_done");
    read_check(9'h064, "b2b_status1");
    read_check(9'h064, "b2b_status2");
  endtask

  task automatic test_unmapped();
    logic [15:0] x;
    @(negedge Clk); Address = 9'h068; Write = 0; Read = 0;
    @(negedge Clk);
    n_checks++; if ({StartPulse, Busy} !== 2'b00) begin n_fail++; $display("FAIL nowrite start: got %b want 00", {StartPulse, Busy}); end
    read_check(9'h00E, "unmap_mis");
    read_check(9'h1F0, "unmap_hi");
    read_check(9'h068, "start_read");
    do_write(9'h00E, 16'hBEEF);
    check_regs("unmap_wr");
    x = 16'($urandom);
    @(negedge Clk); Address = 9'h060; WriteData = x; Write = 1; Read = 1;
    @(negedge Clk); Write = 0; Read = 0;
    m_ent = x;
    n_checks++; if (ReadValid !== 1'b0) begin n_fail++; $display("FAIL wr_rd rvalid: got %b want 0", ReadValid); end
    n_checks++; if (Entrada !== x) begin n_fail++; $display("FAIL wr_rd entrada: got %h want %h", Entrada, x); end
    read_check(9'h064, "unmap_status");
  endtask

  task automatic test_reset_midrun();
    read_check(9'h060, "pre_rst_read");
    do_write(9'h068, 16'h0);
    #2 Reset_n = 0;
    #1;
    model_reset();
    check_regs("async_rst");
    n_checks++; if (StartPulse !== 1'b0) begin n_fail++; $display("FAIL async_rst start: got %b want 0", StartPulse); end
    n_checks++; if (ReadData !== 16'h0) begin n_fail++; $display("FAIL async_rst rdata: got %h want 0", ReadData); end
    @(negedge Clk); Reset_n = 1;
    read_check(9'h064, "post_rst_status");
  endtask

  task automatic test_small();
    logic [15:0] d;
    d = 16'($urandom);
    @(negedge Clk); a4 = 9'h018; wd4 = d; w4 = 1;
    @(negedge Clk); a4 = 9'h01C; wd4 = ~d;
    @(negedge Clk); w4 = 0;
    n_checks++; if (c4[63:48] !== d) begin n_fail++; $display("FAIL n4 coeff3: got %h want %h", c4[63:48], d); end
    n_checks++; if (o4 !== ~d) begin n_fail++; $display("FAIL n4 offset: got %h want %h", o4, ~d); end
    @(negedge Clk); a4 = 9'h028; w4 = 1;
    @(negedge Clk); w4 = 0;
    n_checks++; if ({sp4, b4} !== 2'b11) begin n_fail++; $display("FAIL n4 start: got %b want 11", {sp4, b4}); end
    @(negedge Clk); a4 = 9'h024; r4 = 1;
    @(negedge Clk); r4 = 0;
    n_checks++; if ({rv4, rd4} !== {1'b1, 16'h0001}) begin n_fail++; $display("FAIL n4 status: got %b/%h want 1/0001", rv4, rd4); end
    @(negedge Clk); a4 = 9'h02C; r4 = 1; d4 = 1;
    @(negedge Clk); r4 = 0; d4 = 0;
    n_checks++; if ({rv4, rd4, b4} !== {1'b1, 16'h0, 1'b0}) begin n_fail++; $display("FAIL n4 unmap/done: got %b/%h/%b want 1/0000/0", rv4, rd4, b4); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_start();
    test_run_lock();
    test_done();
    test_back_to_back();
    test_unmapped();
    test_reset_midrun();
    test_small();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
